program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameters SHALL be: DEPTH, default 8, program words loaded per image; WORD_W, default 9, instruction width; ADDR_W, default 3, RAM address width.
REQ-002 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port reset  input  1  asynchronous, active-low reset.
REQ-004 Port start  input  1  single-cycle request to begin loading an image.
REQ-005 Port ser_valid  input  1  qualifies ser_data this cycle.
REQ-006 Port ser_data  input  1  serial image bit, LSB of each word first.
REQ-007 Port RAM_Write_Data  output  WORD_W  word driven to the CPU RAM external write port.
REQ-008 Port RAM_Write_Address  output  ADDR_W  target RAM row.
REQ-009 Port RAM_Write_Enable  output  1  one-cycle write strobe.
REQ-010 Port PC_Enable  output  1  CPU clock gate; high only after a verified load.
REQ-011 Port busy  output  1  high in RECV and WRITE.
REQ-012 Port done  output  1  high in RUN.
REQ-013 Port error  output  1  high in ERROR.
REQ-014 Port words_loaded  output  ADDR_W+1  count of words written in the current load.

Function
REQ-015 FSM states SHALL be IDLE, RECV, WRITE, RUN, ERROR; all outputs SHALL be Moore, decoded from registered state and datapath registers only.
REQ-016 IDLE: start=1 -> RECV, clearing bit counter, word counter wc, shift register and checksum csum (all zero).
REQ-017 RECV: each cycle with ser_valid=1, shreg <= {ser_data, shreg[WORD_W-1:1]} and bit counter increments; ser_valid=0 holds all state (gaps allowed, no timeout).
REQ-018 RECV: on the valid cycle carrying bit WORD_W-1, bit counter SHALL wrap to 0 and the FSM SHALL go to WRITE if wc<DEPTH, else compare shreg to csum.
REQ-019 WRITE (exactly one cycle): RAM_Write_Enable=1, RAM_Write_Data=shreg, RAM_Write_Address=wc[ADDR_W-1:0]; on exit csum ^= shreg, wc increments, next state RECV.
REQ-020 Checksum word (word DEPTH+1) SHALL NOT be written; match -> RUN, mismatch -> ERROR.
REQ-021 Write strobe SHALL appear the cycle after the clock edge that samples the word's last bit.
REQ-022 RUN: PC_Enable=1 and done=1; start=1 -> RECV with all counters cleared, and PC_Enable SHALL be 0 from the next cycle.
REQ-023 ERROR: PC_Enable=0, error=1; start=1 -> RECV as in REQ-016.
REQ-024 start in RECV or WRITE SHALL be ignored; ser_valid outside RECV SHALL be ignored.
REQ-025 Outside WRITE, RAM_Write_Enable=0 and RAM_Write_Data/RAM_Write_Address SHALL be zero.
REQ-026 words_loaded SHALL equal wc at all times, saturating at DEPTH.

Reset
REQ-027 reset=0 SHALL force IDLE and clear every register asynchronously; all outputs SHALL be 0, including mid-load, where a partial image leaves PC_Enable=0.
REQ-028 After reset release, the first start SHALL be honoured on the first rising edge.

Structure
REQ-029 Package program_loader_pkg SHALL hold the state enum and the WORD_W/ADDR_W defaults shared with the CPU.
REQ-030 Sub-module loader_deser SHALL contain the shift register and bit counter, emitting a one-cycle word_ready with the word; FSM, checksum and counters stay in program_loader.

Verification
REQ-031 Send words 0x001,0x002,0x004,0x008,0x010,0x020,0x040,0x080, then checksum 0x0FF -> eight strobes at addresses 0..7 with those data, then done=1 and PC_Enable=1.
REQ-032 Same words, checksum 0x000 -> eight strobes, then error=1, PC_Enable=0, no ninth strobe.
REQ-033 Same image, ser_valid low 3 cycles between every bit -> identical writes and RUN.
REQ-034 reset=0 after word 3 is written -> all outputs 0 immediately; a fresh load then completes normally.
REQ-035 In RUN, pulse start, then load image 0x1FF x8 with checksum 0x000 -> PC_Enable low from the cycle after start, RAM rows all 0x1FF, RUN reached.
REQ-036 start pulsed mid-RECV -> ignored; wc and write sequence unchanged.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared definitions for the serial program loader: default word and address
// widths (shared with the CPU), loader FSM states, and a small state helper.
package program_loader_pkg;

    localparam int DEPTH_DEFAULT  = 8;
    localparam int WORD_W_DEFAULT = 9;
    localparam int ADDR_W_DEFAULT = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
        RUN   = 3'd3,
        ERROR = 3'd4
    } loader_state_t;

    // A new load may only be requested from a resting state.
    function automatic logic can_start(input loader_state_t s);
        return (s == IDLE) || (s == RUN) || (s == ERROR);
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Serial image input and CPU RAM external write port, bundled together.
// The loader uses the master modport; the image source / RAM side uses slave.
import program_loader_pkg::*;

interface program_loader_if #(
    parameter int WORD_W = WORD_W_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT
);
    logic              ser_valid;
    logic              ser_data;
    logic [WORD_W-1:0] RAM_Write_Data;
    logic [ADDR_W-1:0] RAM_Write_Address;
    logic              RAM_Write_Enable;

    modport master (
        input  ser_valid,
        input  ser_data,
        output RAM_Write_Data,
        output RAM_Write_Address,
        output RAM_Write_Enable
    );

    modport slave (
        output ser_valid,
        output ser_data,
        input  RAM_Write_Data,
        input  RAM_Write_Address,
        input  RAM_Write_Enable
    );
endinterface

// File: rtl/loader_deser.sv
// LSB-first serial-to-parallel converter. word_ready flags the valid cycle
// carrying the last bit, with the assembled word presented alongside it.
module loader_deser #(
    parameter int WORD_W = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              enable,
    input  logic              bit_valid,
    input  logic              bit_data,
    output logic [WORD_W-1:0] shreg,
    output logic [WORD_W-1:0] word,
    output logic              word_ready
);
    localparam int CNT_W = $clog2(WORD_W + 1);

    logic [CNT_W-1:0] bit_cnt;
    logic             take;

    assign take       = enable & bit_valid;
    assign word       = {bit_data, shreg[WORD_W-1:1]};
    assign word_ready = take && (bit_cnt == CNT_W'(WORD_W - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (clear) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (take) begin
            shreg   <= word;
            bit_cnt <= word_ready ? '0 : bit_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Loads DEPTH serial words into the CPU RAM, then checks a trailing XOR
// checksum word and only enables the CPU clock if the image verifies.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int WORD_W = WORD_W_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    program_loader_if.master  bus,
    output logic              PC_Enable,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    loader_state_t     state_q, state_d;
    logic [ADDR_W:0]   wc;
    logic [WORD_W-1:0] csum;
    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] word;
    logic              word_ready;
    logic              clear;

    assign clear = start & can_start(state_q);

    loader_deser #(.WORD_W(WORD_W)) u_deser (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .enable     (state_q == RECV),
        .bit_valid  (bus.ser_valid),
        .bit_data   (bus.ser_data),
        .shreg      (shreg),
        .word       (word),
        .word_ready (word_ready)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Once DEPTH words are in, the next complete word is the checksum and is never written.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, RUN, ERROR: begin
                if (start) begin
                    state_d = RECV;
                end
            end
            RECV: begin
                if (word_ready) begin
                    if (wc < DEPTH_W) begin
                        state_d = WRITE;
                    end else if (word == csum) begin
                        state_d = RUN;
                    end else begin
                        state_d = ERROR;
                    end
                end
            end
            WRITE:   state_d = RECV;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wc   <= '0;
            csum <= '0;
        end else if (clear) begin
            wc   <= '0;
            csum <= '0;
        end else if (state_q == WRITE) begin
            wc   <= wc + 1'b1;
            csum <= csum ^ shreg;
        end
    end

    always_comb begin
        bus.RAM_Write_Enable  = 1'b0;
        bus.RAM_Write_Data    = '0;
        bus.RAM_Write_Address = '0;
        if (state_q == WRITE) begin
            bus.RAM_Write_Enable  = 1'b1;
            bus.RAM_Write_Data    = shreg;
            bus.RAM_Write_Address = wc[ADDR_W-1:0];
        end
    end

    assign PC_Enable    = (state_q == RUN);
    assign done         = (state_q == RUN);
    assign error        = (state_q == ERROR);
    assign busy         = (state_q == RECV) || (state_q == WRITE);
    assign words_loaded = (wc > DEPTH_W) ? DEPTH_W : wc;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: a phase-level model of the load protocol checked
// every cycle, plus literal checks on the write log and status flags.
module tb_program_loader;

    localparam int DEPTH  = 8;
    localparam int WORD_W = 9;
    localparam int ADDR_W = 3;

    localparam int P_IDLE  = 0;
    localparam int P_RECV  = 1;
    localparam int P_WRITE = 2;
    localparam int P_RUN   = 3;
    localparam int P_ERR   = 4;

    logic            clk   = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic            PC_Enable, busy, done, error;
    logic [ADDR_W:0] words_loaded;

    int total = 0;
    int bad   = 0;

    program_loader_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) bus ();

    program_loader #(.DEPTH(DEPTH), .WORD_W(WORD_W), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .bus          (bus),
        .PC_Enable    (PC_Enable),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    // Protocol model: words are assembled arithmetically from the bits sent.
    int m_phase = P_IDLE;
    int m_nbits = 0;
    int m_word  = 0;
    int m_count = 0;
    int m_sum   = 0;
    int m_last  = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_phase = P_IDLE;
            m_nbits = 0;
            m_word  = 0;
            m_count = 0;
            m_sum   = 0;
            m_last  = 0;
        end else begin
            case (m_phase)
                P_IDLE, P_RUN, P_ERR: begin
                    if (start) begin
                        m_phase = P_RECV;
                        m_nbits = 0;
                        m_word  = 0;
                        m_count = 0;
                        m_sum   = 0;
                        m_last  = 0;
                    end
                end
                P_RECV: begin
                    if (bus.ser_valid) begin
                        m_word  = m_word + (int'(bus.ser_data) << m_nbits);
                        m_nbits = m_nbits + 1;
                        if (m_nbits == WORD_W) begin
                            if (m_count < DEPTH) begin
                                m_last  = m_word;
                                m_phase = P_WRITE;
                            end else begin
                                m_phase = (m_word == m_sum) ? P_RUN : P_ERR;
                            end
                            m_nbits = 0;
                            m_word  = 0;
                        end
                    end
                end
                P_WRITE: begin
                    m_sum   = m_sum ^ m_last;
                    m_count = m_count + 1;
                    m_phase = P_RECV;
                end
                default: m_phase = P_IDLE;
            endcase
        end
    end

    task automatic check_output(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, want %0h at %0t", name, actual, expected, $time);
        end
    endtask

    int         log_n = 0;
    logic [8:0] log_data [32];
    logic [2:0] log_addr [32];
    logic [8:0] tb_ram [8];

    // Every-cycle comparison against the model, plus the write log.
    always @(negedge clk) begin
        check_output("we",    int'(bus.RAM_Write_Enable), int'(m_phase == P_WRITE));
        check_output("wdata", int'(bus.RAM_Write_Data), (m_phase == P_WRITE) ? m_last : 0);
        check_output("waddr", int'(bus.RAM_Write_Address), (m_phase == P_WRITE) ? m_count : 0);
        check_output("pc_en", int'(PC_Enable), int'(m_phase == P_RUN));
        check_output("done",  int'(done),      int'(m_phase == P_RUN));
        check_output("error", int'(error),     int'(m_phase == P_ERR));
        check_output("busy",  int'(busy),      int'(m_phase == P_RECV || m_phase == P_WRITE));
        check_output("wl",    int'(words_loaded), (m_count > DEPTH) ? DEPTH : m_count);
        if (bus.RAM_Write_Enable) begin
            if (log_n < 32) begin
                log_data[log_n] = bus.RAM_Write_Data;
                log_addr[log_n] = bus.RAM_Write_Address;
            end
            log_n++;
            tb_ram[bus.RAM_Write_Address] = bus.RAM_Write_Data;
        end
    end

    logic [8:0] img [8];

    task automatic apply_stimulus();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_word(input logic [8:0] w, input int gap);
        logic [8:0] wv;
        wv = w;
        for (int b = 0; b < WORD_W; b++) begin
            @(negedge clk);
            bus.ser_valid = 1'b1;
            bus.ser_data  = wv[b];
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                bus.ser_valid = 1'b0;
                bus.ser_data  = 1'b0;
            end
        end
        @(negedge clk);
        bus.ser_valid = 1'b0;
        bus.ser_data  = 1'b0;
    endtask

    task automatic send_range(input int from, input int upto, input int gap);
        for (int i = from; i < upto; i++) begin
            send_word(img[i], gap);
        end
    endtask

    task automatic wait_final(input string name);
        for (int i = 0; i < 60 && !(done || error); i++) begin
            @(negedge clk);
        end
        check_output(name, int'(done | error), 1);
    endtask

    task automatic check_log_onehot(input string name);
        check_output({name, "_n"}, log_n, 8);
        for (int i = 0; i < 8; i++) begin
            check_output({name, "_addr"}, int'(log_addr[i]), i);
            check_output({name, "_data"}, int'(log_data[i]), 1 << i);
        end
    endtask

    initial begin
        bus.ser_valid = 1'b0;
        bus.ser_data  = 1'b0;
        for (int i = 0; i < 8; i++) img[i] = 9'(1 << i);
        #1 reset = 1'b0;
        #21 reset = 1'b1;

        // Clean one-hot image with matching checksum 0x0FF.
        log_n = 0;
        apply_stimulus();
        send_range(0, 8, 0);
        send_word(9'h0FF, 0);
        wait_final("t1_final");
        check_output("t1_done", int'(done), 1);
        check_output("t1_pc", int'(PC_Enable), 1);
        check_log_onehot("t1");

        // Same image, bad checksum: error, no ninth strobe.
        apply_stimulus();
        log_n = 0;
        send_range(0, 8, 0);
        send_word(9'h000, 0);
        wait_final("t2_final");
        repeat (3) @(negedge clk);
        check_output("t2_error", int'(error), 1);
        check_output("t2_pc", int'(PC_Enable), 0);
        check_log_onehot("t2");

        // Gaps of three idle cycles between bits.
        apply_stimulus();
        log_n = 0;
        send_range(0, 8, 3);
        send_word(9'h0FF, 3);
        wait_final("t3_final");
        check_output("t3_done", int'(done), 1);
        check_log_onehot("t3");

        // Reset mid-load after word 3 is written, then a fresh load.
        apply_stimulus();
        send_range(0, 4, 0);
        @(negedge clk);
        check_output("t4_busy_pre", int'(busy), 1);
        #2 reset = 1'b0;
        #1;
        check_output("t4_busy", int'(busy), 0);
        check_output("t4_wl", int'(words_loaded), 0);
        check_output("t4_pc", int'(PC_Enable), 0);
        check_output("t4_we", int'(bus.RAM_Write_Enable), 0);
        check_output("t4_flags", int'({done, error}), 0);
        @(negedge clk);
        #2 reset = 1'b1;
        apply_stimulus();
        log_n = 0;
        send_range(0, 8, 0);
        send_word(9'h0FF, 0);
        wait_final("t4_final");
        check_output("t4_done", int'(done), 1);
        check_log_onehot("t4");

        // Restart from RUN with an all-ones image (checksum 0).
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_output("t5_pc_off", int'(PC_Enable), 0);
        check_output("t5_busy", int'(busy), 1);
        for (int i = 0; i < 8; i++) img[i] = 9'h1FF;
        send_range(0, 8, 0);
        send_word(9'h000, 0);
        wait_final("t5_final");
        check_output("t5_done", int'(done), 1);
        for (int i = 0; i < 8; i++) check_output("t5_ram", int'(tb_ram[i]), 9'h1FF);

        // start during RECV is ignored.
        for (int i = 0; i < 8; i++) img[i] = 9'(1 << i);
        apply_stimulus();
        log_n = 0;
        send_range(0, 2, 0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_output("t6_wl", int'(words_loaded), 2);
        send_range(2, 8, 0);
        send_word(9'h0FF, 0);
        wait_final("t6_final");
        check_output("t6_done", int'(done), 1);
        check_log_onehot("t6");

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
